btb_2way: RTL

- Two-way set-associative Branch Target Buffer (BTB) that sits beside the fetch-stage PC mux.
- Fetch side: looks up PC_F in the same cycle and supplies a predicted target plus a hit flag, so the PC mux can redirect alongside the gshare direction bit.
- Execute side: updated from the execute stage when a branch or jump resolves taken.
- Includes a sequential bulk-invalidate engine used on context or code changes.

---
 rtl/btb_2way.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/btb_2way.sv
// btb_2way: two-way set-associative branch target buffer.
//
// A combinational lookup from fetch (PC_F) supplies a predicted target and a
// hit flag. A registered update from execute (PC_EX/target_EX) either
// retargets an existing entry or allocates a new one. The per-set LRU bit
// names the victim way. A sequential sweep invalidates one set per cycle
// after a clear_en pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   read_en    fetch lookup valid
//   stall_F    fetch stalled; a read does not touch the LRU
//   PC_F       fetch PC
//   hit_F      lookup hit (combinational)
//   target_F   predicted target, 0 on miss
//   write_en   resolved-taken update from execute
//   PC_EX      PC of the resolving instruction
//   target_EX  resolved target
//   clear_en   start a bulk invalidate (pulse)
//   busy       invalidate sweep in progress
//
// Invalidate FSM
//   state | meaning
//   IDLE  | normal operation; clear_en starts a sweep at set 0
//   SWEEP | clearing set cnt each cycle; lookups miss, writes are dropped
module btb_2way #(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  input  logic             stall_F,
  input  logic [WIDTH-1:0] PC_F,
  output logic             hit_F,
  output logic [WIDTH-1:0] target_F,
  input  logic             write_en,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic [WIDTH-1:0] target_EX,
  input  logic             clear_en,
  output logic             busy
);

  localparam int SETS = 1 << INDEX_BITS;
  localparam int TAG_LO = INDEX_BITS + 2;
  localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state, state_next;
  logic [INDEX_BITS-1:0] cnt, cnt_next;

  logic [SETS-1:0]       valid0, valid1, lru;
  logic [TAG_BITS-1:0]   tag0  [SETS];
  logic [TAG_BITS-1:0]   tag1  [SETS];
  logic [WIDTH-1:0]      data0 [SETS];
  logic [WIDTH-1:0]      data1 [SETS];

  logic [INDEX_BITS-1:0] ridx, widx;
  logic [TAG_BITS-1:0]   rtag, wtag;
  logic                  rm0, rm1, wm0, wm1;
  logic                  rd_upd, wr_do, way_w;

  // Byte-offset and upper PC bits take no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_F[1:0], PC_F[WIDTH-1:TAG_HI+1],
                            PC_EX[1:0], PC_EX[WIDTH-1:TAG_HI+1]};

  assign ridx = PC_F[TAG_LO-1:2];
  assign rtag = PC_F[TAG_HI:TAG_LO];
  assign widx = PC_EX[TAG_LO-1:2];
  assign wtag = PC_EX[TAG_HI:TAG_LO];

  // Lookup
  assign rm0 = valid0[ridx] && (tag0[ridx] == rtag);
  assign rm1 = valid1[ridx] && (tag1[ridx] == rtag);

  assign hit_F = read_en && !busy && (rm0 || rm1);

  always_comb begin
    target_F = '0;
    if (hit_F) target_F = rm0 ? data0[ridx] : data1[ridx];
  end

  assign rd_upd = hit_F && !stall_F;

  // Update: a tag match retargets in place; otherwise fill an invalid way
  // (way0 first) and fall back to the LRU victim.
  assign wm0   = valid0[widx] && (tag0[widx] == wtag);
  assign wm1   = valid1[widx] && (tag1[widx] == wtag);
  assign wr_do = write_en && !busy;

  always_comb begin
    if (wm0)               way_w = 1'b0;
    else if (wm1)          way_w = 1'b1;
    else if (!valid0[widx]) way_w = 1'b0;
    else if (!valid1[widx]) way_w = 1'b1;
    else                   way_w = lru[widx];
  end

  // Valid and LRU state; the write update is last so it wins over a read
  // touching the same set in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (state == SWEEP) begin
        valid0[cnt] <= 1'b0;
        valid1[cnt] <= 1'b0;
        lru[cnt]    <= 1'b0;
      end
      if (rd_upd) lru[ridx] <= rm0;
      if (wr_do) begin
        if (way_w) valid1[widx] <= 1'b1;
        else       valid0[widx] <= 1'b1;
        lru[widx] <= ~way_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      if (way_w) begin
        tag1[widx]  <= wtag;
        data1[widx] <= target_EX;
      end else begin
        tag0[widx]  <= wtag;
        data0[widx] <= target_EX;
      end
    end
  end

  // Invalidate FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Invalidate FSM: next state
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clear_en) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        cnt_next = cnt + 1'b1;
        if (cnt == INDEX_BITS'(SETS - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Invalidate FSM: outputs
  always_comb begin
    busy = (state == SWEEP);
  end

endmodule
